multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Control FSM for the multicycle RV32I core: it replaces the single-cycle main/ALU decoder pair when the datapath shares one memory port and one ALU across cycles. It sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction and stalls on a memory-ready handshake. It adds optional `bne`, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register and the multicycle datapath mux/enable pins.

## Interface
- `EN_BNE`, default 1: when 1, the branch state also resolves `bne` (funct3=001); when 0, only `beq` is taken.
- `MEM_WAIT`, default 1: when 1, `MemReady` gates progress in FETCH, MEMREAD and MEMWRITE; when 0, `MemReady` is ignored and treated as 1.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `OP`  in  7  opcode from the instruction register.
- `funct3`  in  3  instruction bits [14:12].
- `funct7`  in  1  instruction bit 30.
- `Zero`  in  1  ALU zero flag.
- `MemReady`  in  1  shared memory has completed the current access this cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, `AdrSrc`  out  1 each  datapath enables and selects.
- `ResultSrc`, `ALUSrcA`, `ALUSrcB`, `ImmSrc`  out  2 each  mux selects.
- `ALUControl`  out  3  encodings: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `Illegal`  out  1  sticky flag for an unsupported opcode.
- `InstRet`  out  CNT_W  count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH, TRAP.
- FETCH: AdrSrc=0, ALUSrcA=00 (PC), ALUSrcB=10 (+4), ALUOp=add, ResultSrc=10.
  - IRWrite and PCWrite are asserted only when `MemReady`=1.
  - Advance to DECODE on `MemReady`; otherwise hold.
- DECODE: ALUSrcA=01 (OldPC), ALUSrcB=01 (imm), add; this precomputes the branch target.
  - OP dispatch: lw/sw → MEMADR; R-type → EXECR; I-ALU → EXECI; jal → JAL; 1100011 → BRANCH.
  - Any other opcode → TRAP.
- MEMADR: ALUSrcA=10 (rs1), ALUSrcB=01, add. Next state is MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until `MemReady`, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held while waiting. Go to FETCH on `MemReady`.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct decode, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct decode, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB (writes PC+4 to rd).
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, then FETCH.
  - PCWrite = taken, where taken = Zero for funct3=000, and ~Zero for funct3=001 when EN_BNE=1.
  - Any other funct3 is not taken.
- Funct decode:
  - funct3 000 gives sub when OP[5]&funct7, else add.
  - 010 → slt; 110 → or; 111 → and; anything else → add.
- ImmSrc is decoded from OP in every state: lw/I-ALU 00, sw 01, branch 10, jal 11, others 00.
- TRAP: terminal state with `Illegal`=1 and all write enables 0. Only `reset` exits it.
- Retire: `InstRet` increments by 1 on the edge leaving MEMWB, MEMWRITE (with ready), ALUWB or BRANCH. It wraps modulo 2^CNT_W.

## Timing
- While `reset`=1:
  - State is FETCH, `InstRet`=0, `Illegal`=0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced 0; the selects show FETCH values.
- Deassertion is sampled at the next rising edge. Reset asserted mid-instruction aborts it with no retire.
- Outputs are Moore from the state, except these terms, which depend combinationally on inputs in the current state:
  - PCWrite/IRWrite in FETCH (`MemReady`).
  - PCWrite in BRANCH (`Zero`).
  - ALUControl (`funct3`, `funct7`, `OP`).
- Cycles per instruction with `MemReady` always 1:
  - lw 5.
  - sw 4.
  - R-type, I-ALU and jal 4.
  - branch 3.
- Each cycle of `MemReady`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.

## Structure
- A shared package holds:
  - the state enum;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR);
  - ALUControl and ALUOp encodings.
- The sub-module `alu_decoder` (ALUOp, funct3, funct7, OP[5] → ALUControl) is combinational and reused from the single-cycle design's encoding.

## Test plan
- Hold reset high, then release, with `MemReady`=1 and the IR holding `lw` (OP=0000011):
  - state sequence FETCH→DECODE→MEMADR→MEMREAD→MEMWB→FETCH;
  - RegWrite=1 only in MEMWB; `InstRet`=1 after 5 cycles.
- Issue `sw` with `MemReady` low for 3 cycles in MEMWRITE: MemWrite is held for 4 cycles, and `InstRet` increments only on the ready cycle.
- `sub` (OP=0110011, funct3=000, funct7=1): ALUControl=001 in EXECR. Same instruction as `addi` (OP=0010011, funct7=1): ALUControl=000.
- `bne` (funct3=001) with EN_BNE=1:
  - Zero=0 gives PCWrite=1 in BRANCH;
  - Zero=1 gives PCWrite=0;
  - with EN_BNE=0, PCWrite=0 in both cases.
- OP=0110111 at DECODE:
  - TRAP entered and `Illegal`=1 sticks for 20 cycles with all enables 0;
  - reset clears both.
- Preload `InstRet` to near wrap with CNT_W=4 by running 16 `add`s: count returns to 0. Reset asserted in EXECR: no increment, and the next cycle is FETCH.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : multicycle_control_unit_pkg                               |
// | Purpose  : Shared types and constants for the multicycle RV32I       |
// |            control unit: FSM state enum, opcode constants, ALUOp     |
// |            and ALUControl encodings, datapath mux-select values and  |
// |            the immediate-format decode helper.                       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package multicycle_control_unit_pkg;

   // Control FSM states
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   // Supported opcodes
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   // ALUOp: what the FSM asks of the ALU decoder
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   // ALUControl encodings shared with the single-cycle ALU
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result mux select
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Immediate format from the opcode; independent of FSM state.
   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      logic [1:0] imm;
      case (op)
         OP_LW, OP_I: imm = 2'b00;
         OP_SW:       imm = 2'b01;
         OP_BR:       imm = 2'b10;
         OP_JAL:      imm = 2'b11;
         default:     imm = 2'b00;
      endcase
      return imm;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_decoder                                               |
// | Purpose  : Combinational ALUOp/funct decode to ALUControl, same      |
// |            encoding as the single-cycle core.                        |
// | Ports    : aluop      in  2  request from the control FSM            |
// |            funct3     in  3  instruction bits [14:12]                |
// |            funct7     in  1  instruction bit 30                      |
// |            op5        in  1  opcode bit 5 (R-type vs I-type)         |
// |            alucontrol out 3  ALU operation select                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_decoder
   import multicycle_control_unit_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic       op5,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7 only means sub for register-register ops; addi
               // with bit 30 set is still an add.
               3'b000:  alucontrol = (op5 & funct7) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol = ALU_SLT;
               3'b110:  alucontrol = ALU_OR;
               3'b111:  alucontrol = ALU_AND;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : multicycle_control_unit                                   |
// | Purpose  : Control FSM for the multicycle RV32I core. Sequences      |
// |            fetch/decode/execute/memory/writeback over 3-5 cycles,    |
// |            stalls on the shared-memory ready handshake, traps on     |
// |            unsupported opcodes and counts retired instructions.      |
// | Params   : EN_BNE   1 = branch state also resolves bne               |
// |            MEM_WAIT 1 = MemReady gates FETCH/MEMREAD/MEMWRITE        |
// |            CNT_W    retired-instruction counter width                |
// | Ports    : clk, reset (async, active-high)                           |
// |            OP[6:0], funct3[2:0], funct7, Zero, MemReady  inputs      |
// |            PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  enables     |
// |            ResultSrc, ALUSrcA, ALUSrcB, ImmSrc [1:0]     selects     |
// |            ALUControl[2:0], Illegal, InstRet[CNT_W-1:0]              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter bit EN_BNE   = 1'b1,
   parameter bit MEM_WAIT = 1'b1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       OP,
   input  logic [2:0]       funct3,
   input  logic             funct7,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             AdrSrc,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ImmSrc,
   output logic [2:0]       ALUControl,
   output logic             Illegal,
   output logic [CNT_W-1:0] InstRet
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_instret;

   logic   w_ready;
   logic   w_taken;
   logic   w_retire;
   aluop_t w_aluop;
   logic   w_pcwrite;
   logic   w_irwrite;
   logic   w_regwrite;
   logic   w_memwrite;

   // With MEM_WAIT=0 the memory is assumed single-cycle.
   assign w_ready = MEM_WAIT ? MemReady : 1'b1;

   // beq always; bne only when enabled; other funct3 never taken.
   assign w_taken = ((funct3 == 3'b000) &  Zero) |
                    (EN_BNE & (funct3 == 3'b001) & ~Zero);

   // An instruction retires on the edge that leaves its last state.
   assign w_retire = (r_state == S_MEMWB)  ||
                     (r_state == S_ALUWB)  ||
                     (r_state == S_BRANCH) ||
                     ((r_state == S_MEMWRITE) && w_ready);

   // ------------------------------------------------------------------
   // State register and retired-instruction counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instret <= '0;
      end else if (w_retire) begin
         r_instret <= r_instret + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (OP)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECR;
               OP_I:         w_next = S_EXECI;
               OP_JAL:       w_next = S_JAL;
               OP_BR:        w_next = S_BRANCH;
               default:      w_next = S_TRAP;
            endcase
         end
         S_MEMADR:   w_next = (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR:    w_next = S_ALUWB;
         S_EXECI:    w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_JAL:      w_next = S_ALUWB;
         S_BRANCH:   w_next = S_FETCH;
         S_TRAP:     w_next = S_TRAP;
         default:    w_next = S_FETCH;
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      w_pcwrite  = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_memwrite = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      w_aluop    = ALUOP_ADD;
      case (r_state)
         S_FETCH: begin
            // PC+4 is written back through the ALU result path while the
            // instruction word is captured from memory.
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            w_irwrite = w_ready;
            w_pcwrite = w_ready;
         end
         S_DECODE: begin
            // Precompute the branch/jump target from the old PC.
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc  = RES_DATA;
            w_regwrite = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            w_memwrite = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = SRCA_RS1;
            w_aluop = ALUOP_FUNCT;
         end
         S_EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            w_aluop = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            w_regwrite = 1'b1;
         end
         S_JAL: begin
            // Jump to the target computed in DECODE; ALU forms OldPC+4
            // for the link register write in ALUWB.
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            w_pcwrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA   = SRCA_RS1;
            w_aluop   = ALUOP_SUB;
            w_pcwrite = w_taken;
         end
         default: begin
            // TRAP: everything idle.
         end
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop      (w_aluop),
      .funct3     (funct3),
      .funct7     (funct7),
      .op5        (OP[5]),
      .alucontrol (ALUControl)
   );

   // Reset forces the state to FETCH asynchronously; the write enables
   // are also masked so a ready memory cannot fire IRWrite mid-reset.
   assign PCWrite  = w_pcwrite  & ~reset;
   assign IRWrite  = w_irwrite  & ~reset;
   assign RegWrite = w_regwrite & ~reset;
   assign MemWrite = w_memwrite & ~reset;

   assign ImmSrc  = imm_src_of(OP);
   assign Illegal = (r_state == S_TRAP);
   assign InstRet = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_multicycle_control_unit                                |
// | Purpose  : Directed self-checking bench for multicycle_control_unit. |
// |            Two instances (bne enabled / disabled) share stimulus.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_multicycle_control_unit;

   localparam int CNT_W = 4;

   localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                  MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, JAL = 9,
                  BRANCH = 10, TRAP = 11;

   localparam logic [6:0] C_LW = 7'b0000011, C_SW = 7'b0100011,
                          C_R = 7'b0110011, C_I = 7'b0010011,
                          C_JAL = 7'b1101111, C_BR = 7'b1100011,
                          C_LUI = 7'b0110111;

   // Signature field masks: {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,
   // ResultSrc[1:0],ALUSrcA[1:0],ALUSrcB[1:0],ImmSrc[1:0],ALUControl[2:0],Illegal}
   localparam logic [16:0] M_ADR = 17'h01000, M_RES = 17'h00C00,
                           M_A = 17'h00300, M_B = 17'h000C0, M_CTL = 17'h0000E;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] f3;
   logic       f7, zero, ready;

   logic             pcw_a, irw_a, rw_a, mw_a, adr_a, ill_a;
   logic [1:0]       res_a, sa_a, sb_a, imm_a;
   logic [2:0]       ctl_a;
   logic [CNT_W-1:0] ir_a;
   logic             pcw_b, irw_b, rw_b, mw_b, adr_b, ill_b;
   logic [1:0]       res_b, sa_b, sb_b, imm_b;
   logic [2:0]       ctl_b;
   logic [CNT_W-1:0] ir_b;

   always #5 clk = ~clk;

   multicycle_control_unit #(.EN_BNE(1'b1), .MEM_WAIT(1'b1), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .OP(op), .funct3(f3), .funct7(f7), .Zero(zero),
      .MemReady(ready), .PCWrite(pcw_a), .IRWrite(irw_a), .RegWrite(rw_a),
      .MemWrite(mw_a), .AdrSrc(adr_a), .ResultSrc(res_a), .ALUSrcA(sa_a),
      .ALUSrcB(sb_a), .ImmSrc(imm_a), .ALUControl(ctl_a), .Illegal(ill_a),
      .InstRet(ir_a));

   multicycle_control_unit #(.EN_BNE(1'b0), .MEM_WAIT(1'b1), .CNT_W(CNT_W)) dut_nb (
      .clk(clk), .reset(reset), .OP(op), .funct3(f3), .funct7(f7), .Zero(zero),
      .MemReady(ready), .PCWrite(pcw_b), .IRWrite(irw_b), .RegWrite(rw_b),
      .MemWrite(mw_b), .AdrSrc(adr_b), .ResultSrc(res_b), .ALUSrcA(sa_b),
      .ALUSrcB(sb_b), .ImmSrc(imm_b), .ALUControl(ctl_b), .Illegal(ill_b),
      .InstRet(ir_b));

   wire logic [16:0] sig_a = {pcw_a, irw_a, rw_a, mw_a, adr_a, res_a, sa_a, sb_a,
                              imm_a, ctl_a, ill_a};
   wire logic [16:0] sig_b = {pcw_b, irw_b, rw_b, mw_b, adr_b, res_b, sa_b, sb_b,
                              imm_b, ctl_b, ill_b};

   typedef struct packed {
      logic [16:0]      va;
      logic [16:0]      ma;
      logic [16:0]      vb;
      logic [16:0]      mb;
      logic [CNT_W-1:0] ir;
   } exp_t;

   exp_t        sb_q[$];
   string       tag_q[$];
   logic [CNT_W-1:0] exp_ir;
   int          n_assert = 0;
   int          n_fail   = 0;

   // Reference ALU decode taken directly from the instruction semantics.
   function automatic logic [2:0] ref_funct();
      case (f3)
         3'b000:  return (op[5] && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Expected outputs for a state; fields the state leaves open are masked.
   function automatic void model(input int st, input bit enb,
                                 output logic [16:0] v, output logic [16:0] m);
      logic pcw = 0, irw = 0, rw = 0, mw = 0, adr = 0, ill = 0;
      logic [1:0] res = 2'b00, a = 2'b00, b = 2'b00, imm;
      logic [2:0] ctl = 3'b000;
      m = '1;
      case (st)
         FETCH:    begin b = 2'b10; res = 2'b10; irw = ready; pcw = ready; end
         DECODE:   begin a = 2'b01; b = 2'b01; m &= ~(M_ADR | M_RES); end
         MEMADR:   begin a = 2'b10; b = 2'b01; m &= ~(M_ADR | M_RES); end
         MEMREAD:  begin adr = 1; m &= ~(M_A | M_B | M_CTL); end
         MEMWB:    begin res = 2'b01; rw = 1; m &= ~(M_ADR | M_A | M_B | M_CTL); end
         MEMWRITE: begin adr = 1; mw = 1; m &= ~(M_A | M_B | M_CTL); end
         EXECR:    begin a = 2'b10; ctl = ref_funct(); m &= ~(M_ADR | M_RES); end
         EXECI:    begin a = 2'b10; b = 2'b01; ctl = ref_funct(); m &= ~(M_ADR | M_RES); end
         ALUWB:    begin rw = 1; m &= ~(M_ADR | M_A | M_B | M_CTL); end
         JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; m &= ~M_ADR; end
         BRANCH: begin
            a = 2'b10; ctl = 3'b001; m &= ~M_ADR;
            pcw = (f3 == 3'b000 && zero) || (enb && f3 == 3'b001 && !zero);
         end
         default:  begin ill = 1; m &= ~(M_ADR | M_RES | M_A | M_B | M_CTL); end
      endcase
      if (reset) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
      if (op == C_LW || op == C_I)  imm = 2'b00;
      else if (op == C_SW)          imm = 2'b01;
      else if (op == C_BR)          imm = 2'b10;
      else if (op == C_JAL)         imm = 2'b11;
      else                          imm = 2'b00;
      v = {pcw, irw, rw, mw, adr, res, a, b, imm, ctl, ill};
   endfunction

   task automatic push_exp(input string tag, input int st);
      exp_t e;
      model(st, 1'b1, e.va, e.ma);
      model(st, 1'b0, e.vb, e.mb);
      e.ir = exp_ir;
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic pop_cmp();
      exp_t  e;
      string t;
      n_assert++;
      assert (sb_q.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         t = tag_q.pop_front();
         n_assert++;
         assert ((sig_a & e.ma) === (e.va & e.ma)) else begin
            n_fail++;
            $error("FAIL %s bne_on outputs observed=%h expected=%h mask=%h", t, sig_a, e.va, e.ma);
         end
         n_assert++;
         assert ((sig_b & e.mb) === (e.vb & e.mb)) else begin
            n_fail++;
            $error("FAIL %s bne_off outputs observed=%h expected=%h mask=%h", t, sig_b, e.vb, e.mb);
         end
         n_assert++;
         assert (ir_a === e.ir) else begin
            n_fail++;
            $error("FAIL %s bne_on InstRet observed=%0d expected=%0d", t, ir_a, e.ir);
         end
         n_assert++;
         assert (ir_b === e.ir) else begin
            n_fail++;
            $error("FAIL %s bne_off InstRet observed=%0d expected=%0d", t, ir_b, e.ir);
         end
      end
   endtask

   // One clock cycle in state st: check at the falling edge, then advance.
   task automatic cyc(input string tag, input int st, input bit retire);
      push_exp(tag, st);
      @(negedge clk);
      pop_cmp();
      @(posedge clk);
      #1;
      if (retire) exp_ir = exp_ir + 1'b1;
   endtask

   task automatic set_ins(input logic [6:0] o, input logic [2:0] fn3, input logic fn7);
      op = o; f3 = fn3; f7 = fn7;
   endtask

   task automatic alu_instr(input string tag, input logic [6:0] o,
                            input logic [2:0] fn3, input logic fn7);
      set_ins(o, fn3, fn7);
      cyc({tag, "_fetch"}, FETCH, 0);
      cyc({tag, "_dec"}, DECODE, 0);
      cyc({tag, "_exec"}, (o == C_R) ? EXECR : EXECI, 0);
      cyc({tag, "_wb"}, ALUWB, 1);
   endtask

   task automatic branch_instr(input string tag, input logic [2:0] fn3, input logic z);
      set_ins(C_BR, fn3, 1'b0);
      zero = z;
      cyc({tag, "_fetch"}, FETCH, 0);
      cyc({tag, "_dec"}, DECODE, 0);
      cyc({tag, "_br"}, BRANCH, 1);
      zero = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ready = 1'b1; zero = 1'b0; exp_ir = '0;
      set_ins(C_LW, 3'b010, 1'b0);
      @(posedge clk); #1;
      cyc("reset_hold0", FETCH, 0);
      cyc("reset_hold1", FETCH, 0);
      reset = 1'b0;

      // lw, no stalls: 5 cycles
      cyc("lw_fetch", FETCH, 0);
      cyc("lw_dec", DECODE, 0);
      cyc("lw_adr", MEMADR, 0);
      cyc("lw_read", MEMREAD, 0);
      cyc("lw_wb", MEMWB, 1);

      // sw with one fetch stall and three write wait cycles
      set_ins(C_SW, 3'b010, 1'b0);
      ready = 1'b0; cyc("sw_fetch_stall", FETCH, 0);
      ready = 1'b1; cyc("sw_fetch", FETCH, 0);
      cyc("sw_dec", DECODE, 0);
      cyc("sw_adr", MEMADR, 0);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("sw_wait", MEMWRITE, 0);
      ready = 1'b1; cyc("sw_write", MEMWRITE, 1);

      // lw with one read wait cycle
      set_ins(C_LW, 3'b010, 1'b0);
      cyc("lw2_fetch", FETCH, 0);
      cyc("lw2_dec", DECODE, 0);
      cyc("lw2_adr", MEMADR, 0);
      ready = 1'b0; cyc("lw2_wait", MEMREAD, 0);
      ready = 1'b1; cyc("lw2_read", MEMREAD, 0);
      cyc("lw2_wb", MEMWB, 1);

      // funct decode
      alu_instr("sub", C_R, 3'b000, 1'b1);
      alu_instr("addi_f7", C_I, 3'b000, 1'b1);
      alu_instr("slt", C_R, 3'b010, 1'b0);
      alu_instr("or", C_R, 3'b110, 1'b0);
      alu_instr("andi", C_I, 3'b111, 1'b0);
      alu_instr("xor_as_add", C_R, 3'b100, 1'b0);

      // jal
      set_ins(C_JAL, 3'b000, 1'b0);
      cyc("jal_fetch", FETCH, 0);
      cyc("jal_dec", DECODE, 0);
      cyc("jal_jump", JAL, 0);
      cyc("jal_wb", ALUWB, 1);

      // branches
      branch_instr("bne_z0", 3'b001, 1'b0);
      branch_instr("bne_z1", 3'b001, 1'b1);
      branch_instr("beq_z1", 3'b000, 1'b1);
      branch_instr("beq_z0", 3'b000, 1'b0);
      branch_instr("blt_z1", 3'b100, 1'b1);

      // illegal opcode: TRAP is terminal until reset
      set_ins(C_LUI, 3'b000, 1'b0);
      cyc("lui_fetch", FETCH, 0);
      cyc("lui_dec", DECODE, 0);
      for (int i = 0; i < 20; i++) begin
         ready = 1'($urandom_range(0, 1));
         zero  = 1'($urandom_range(0, 1));
         cyc("trap_hold", TRAP, 0);
      end
      ready = 1'b1; zero = 1'b0;
      reset = 1'b1; exp_ir = '0;
      #1;
      push_exp("trap_async_reset", FETCH);
      pop_cmp();
      @(posedge clk); #1;
      cyc("trap_reset_hold", FETCH, 0);
      reset = 1'b0;

      // 16 adds wrap the 4-bit counter back to 0
      for (int i = 0; i < 16; i++) alu_instr("add_wrap", C_R, 3'b000, 1'b0);

      // reset mid-execute aborts the instruction
      set_ins(C_R, 3'b000, 1'b0);
      cyc("abort_fetch", FETCH, 0);
      cyc("abort_dec", DECODE, 0);
      push_exp("abort_exec", EXECR);
      @(negedge clk);
      pop_cmp();
      #1 reset = 1'b1;
      #1;
      exp_ir = '0;
      push_exp("abort_async_reset", FETCH);
      pop_cmp();
      @(posedge clk); #1;
      reset = 1'b0;
      cyc("abort_after_fetch", FETCH, 0);
      cyc("abort_after_dec", DECODE, 0);
      cyc("abort_after_exec", EXECR, 0);
      cyc("abort_after_wb", ALUWB, 1);
      cyc("final_fetch", FETCH, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
